rr_arbiter4: RTL and testbench

Four-requester arbiter that shares one resource (for example a 4-input encoder path or a shared bus slot) between requesters. It wraps a rotated 4-to-2 priority pick and adds grant holding, release handshake, hold timeout and round-robin fairness. It sits between requester logic and the shared resource, and drives a one-hot grant plus a 2-bit grant index.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_pick4.sv | 34 +++
 rtl/rr_arbiter4.sv | 103 ++++++++++
 tb/tb_rr_arbiter4.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the four-requester arbiter
package arb_pkg;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Next search start after an owner leaves; wraps 3 -> 0 through the 2-bit width.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return id + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - rotated 4-to-2 priority pick starting the search at ptr
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  pick_id,
  output logic [NREQ-1:0] pick_oh
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] dbl_rot;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    rank;

  // Rotate so the requester at ptr lands in bit 0.
  assign dbl     = {req, req};
  assign dbl_rot = dbl >> ptr;
  assign rot     = dbl_rot[NREQ-1:0];

  always_comb begin
    rank = 2'd0;
    if (rot[0])      rank = 2'd0;
    else if (rot[1]) rank = 2'd1;
    else if (rot[2]) rank = 2'd2;
    else if (rot[3]) rank = 2'd3;
  end

  assign any     = |req;
  assign pick_id = any ? (ptr + rank) : '0;
  assign pick_oh = any ? (4'b0001 << pick_id) : '0;

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester arbiter with grant hold, release, timeout and round-robin
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int RR       = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_id,
  output logic            valid,
  output logic            timeout
);

  localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(HOLD_MAX - 1);

  arb_state_t      state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [IDW-1:0]  ptr, ptr_n;
  logic [NREQ-1:0] grant_n;
  logic [IDW-1:0]  gnt_id_n;
  logic            timeout_n;

  logic            any;
  logic [IDW-1:0]  pick_id;
  logic [NREQ-1:0] pick_oh;
  logic            rel;
  logic            at_limit;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr),
    .any     (any),
    .pick_id (pick_id),
    .pick_oh (pick_oh)
  );

  // A release always wins over the hold limit, so timeout only fires without one.
  assign rel      = done || !req[gnt_id];
  assign at_limit = (cnt == CNT_LIMIT);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    grant_n   = grant;
    gnt_id_n  = gnt_id;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_n  = GRANT;
          grant_n  = pick_oh;
          gnt_id_n = pick_id;
          cnt_n    = '0;
        end else begin
          grant_n  = '0;
          gnt_id_n = '0;
        end
      end
      GRANT: begin
        if (rel || at_limit) begin
          state_n   = IDLE;
          grant_n   = '0;
          gnt_id_n  = '0;
          ptr_n     = (RR != 0) ? next_id(gnt_id) : '0;
          timeout_n = !rel;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n  = IDLE;
        grant_n  = '0;
        gnt_id_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      grant   <= '0;
      gnt_id  <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
      grant   <= grant_n;
      gnt_id  <= gnt_id_n;
      timeout <= timeout_n;
    end
  end

  assign valid = |grant;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - scoreboard bench for rr_arbiter4 against a behavioural model
module tb_rr_arbiter4;

  localparam int ND = 3;
  // dut 0: RR=1 HOLD_MAX=4, dut 1: RR=0 HOLD_MAX=4, dut 2: RR=1 HOLD_MAX=1
  int p_rr   [ND] = '{1, 0, 1};
  int p_hold [ND] = '{4, 4, 1};

  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic done;

  logic [ND-1:0][3:0] grant_w;
  logic [ND-1:0][1:0] id_w;
  logic [ND-1:0]      valid_w;
  logic [ND-1:0]      tmo_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.RR(1), .HOLD_MAX(4)) dut0 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant_w[0]), .gnt_id(id_w[0]), .valid(valid_w[0]), .timeout(tmo_w[0]));
  rr_arbiter4 #(.RR(0), .HOLD_MAX(4)) dut1 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant_w[1]), .gnt_id(id_w[1]), .valid(valid_w[1]), .timeout(tmo_w[1]));
  rr_arbiter4 #(.RR(1), .HOLD_MAX(1)) dut2 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant_w[2]), .gnt_id(id_w[2]), .valid(valid_w[2]), .timeout(tmo_w[2]));

  // Reference: owner is -1 when nobody holds the resource; held counts cycles of ownership.
  int m_owner [ND];
  int m_held  [ND];
  int m_start [ND];
  int m_tmo   [ND];

  typedef struct packed {
    logic [ND-1:0][7:0] exp;
  } sb_item_t;
  sb_item_t sb[$];

  task automatic model_step(input logic r, input logic [3:0] q, input logic d);
    for (int k = 0; k < ND; k++) begin
      if (r) begin
        m_owner[k] = -1; m_held[k] = 0; m_start[k] = 0; m_tmo[k] = 0;
      end else if (m_owner[k] < 0) begin
        m_tmo[k] = 0;
        for (int s = 0; s < 4; s++) begin
          if (m_owner[k] < 0 && q[(m_start[k] + s) % 4]) m_owner[k] = (m_start[k] + s) % 4;
        end
        m_held[k] = 1;
      end else if (d || !q[m_owner[k]]) begin
        m_start[k] = p_rr[k] != 0 ? (m_owner[k] + 1) % 4 : 0;
        m_owner[k] = -1; m_tmo[k] = 0;
      end else if (m_held[k] >= p_hold[k]) begin
        m_start[k] = p_rr[k] != 0 ? (m_owner[k] + 1) % 4 : 0;
        m_owner[k] = -1; m_tmo[k] = 1;
      end else begin
        m_held[k] = m_held[k] + 1;
      end
    end
  endtask

  function automatic logic [7:0] model_out(input int k);
    logic [3:0] g;
    logic [1:0] id;
    g  = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
    id = (m_owner[k] >= 0) ? 2'(m_owner[k]) : 2'd0;
    return {g, id, (m_owner[k] >= 0), (m_tmo[k] != 0)};
  endfunction

  task automatic cycle(input logic r, input logic [3:0] q, input logic d);
    sb_item_t it;
    rst = r; req = q; done = d;
    model_step(r, q, d);
    for (int k = 0; k < ND; k++) it.exp[k] = model_out(k);
    sb.push_back(it);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always begin
    sb_item_t it;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      for (int k = 0; k < ND; k++)
        check($sformatf("dut%0d {grant,id,valid,timeout} t=%0t", k, $time),
              {grant_w[k], id_w[k], valid_w[k], tmo_w[k]}, it.exp[k]);
    end
  end

  initial begin
    int g0;
    int guard;
    logic r, d;
    logic [3:0] q;

    // reset, then reset while requester 2 holds the grant
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);
    check("reset grant", {4'(grant_w[0]), 3'b0, tmo_w[0]}, 8'h00);
    cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b1, 4'b0100, 1'b0);
    check("reset mid-grant", {grant_w[0], id_w[0], valid_w[0], tmo_w[0]}, 8'h00);
    cycle(1'b0, 4'b0100, 1'b0);
    check("regrant after reset", {grant_w[0], id_w[0], valid_w[0], tmo_w[0]}, 8'b0100_10_1_0);

    // basic grant and release
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0110, 1'b0);
    check("req 0110 grant", {grant_w[0], id_w[0], 2'b00}, 8'b0010_01_00);
    cycle(1'b0, 4'b0110, 1'b1);
    check("release drop", {4'b0, grant_w[0]}, 8'h00);
    cycle(1'b0, 4'b0110, 1'b0);
    check("ptr 2 regrant", {4'b0, grant_w[0]}, 8'b0000_0100);

    // fairness with done on every grant
    cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'b1111, (m_owner[0] >= 0));

    // hold timeout on requester 3, then simultaneous done at the limit
    cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'b1000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);
    guard = 0;
    while (!(m_owner[0] >= 0 && m_held[0] == 4) && guard < 10) begin
      cycle(1'b0, 4'b1000, 1'b0);
      guard++;
    end
    cycle(1'b0, 4'b1000, 1'b1);
    check("done at limit", {grant_w[0], 3'b0, tmo_w[0]}, 8'h00);

    // fixed priority: owner 0 drops its request
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b1111, 1'b0);
    check("fixed prio id", {6'b0, id_w[1]}, 8'd0);
    cycle(1'b0, 4'b1110, 1'b0);
    cycle(1'b0, 4'b1110, 1'b0);
    check("fixed prio next id", {6'b0, id_w[1]}, 8'd1);

    // HOLD_MAX=1 with everyone requesting: one grant each per 8 cycles
    cycle(1'b1, 4'b0000, 1'b0);
    g0 = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 4'b1111, 1'b0);
      if (grant_w[2][0]) g0++;
    end
    check("fairness count", 8'(g0), 8'd2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 63) == 0);
      q = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 3) == 0);
      cycle(r, q, d);
    end

    repeat (2) @(negedge clk);
    check("scoreboard drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
